// File: rtl/barrett_rr_scheduler.sv
// Round-robin arbiter sharing one two-stage Barrett reducer (q = 3329) among NUM_REQ requesters.
// Build option: define BARRETT_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module barrett_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*23-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [11:0]           rsp_data,
  output logic                  busy
);
  localparam logic [23:0] Q  = 24'd3329;
  localparam logic [23:0] MU = 24'd5039;

  logic           stall;
  logic           grant_any;
  logic           accept;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] base;
  logic           s1_valid;
  logic [IDW-1:0] s1_id;
  logic [22:0]    s1_op;
  logic [23:0]    prod;
  logic [11:0]    t_est;
  logic [23:0]    tq;
  logic [23:0]    r0;
  logic [23:0]    r1;
  logic [23:0]    r2;
  logic [11:0]    red;

`ifdef BARRETT_SCHED_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [IDW-1:0] ptr;
  assign base = ptr;

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (accept)
      ptr <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end
`endif

  assign stall = rsp_valid & ~rsp_ready;

  // Search starts at base and wraps; the first valid requester wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(base) + k) % NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
  end

  assign accept = grant_any & ~stall & ~rst;

  always_comb begin
    req_ready = '0;
    if (accept)
      req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_op    <= '0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_id <= grant_idx;
        s1_op <= req_data[23*int'(grant_idx) +: 23];
      end
    end
  end

  // Quotient estimate undershoots by at most 2, so two corrective subtractions suffice.
  assign prod  = {13'd0, s1_op[22:12]} * MU;
  assign t_est = 12'(prod >> 12);
  assign tq    = {12'd0, t_est} * Q;
  assign r0    = {1'b0, s1_op} - tq;
  assign r1    = (r0 >= Q) ? r0 - Q : r0;
  assign r2    = (r1 >= Q) ? r1 - Q : r1;
  assign red   = 12'(r2);

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else if (!stall) begin
      rsp_valid <= s1_valid;
      rsp_id    <= s1_id;
      rsp_data  <= red;
    end
  end

  assign busy = s1_valid | rsp_valid;

endmodule

// File: tb/tb_barrett_rr_scheduler.sv
// Self-checking bench for barrett_rr_scheduler: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_barrett_rr_scheduler;
  localparam int NR  = 4;
  localparam int IDW = 2;
`ifdef BARRETT_SCHED_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*23-1:0] req_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [11:0]      rsp_data;
  logic             busy;

  always #5 clk = ~clk;

  barrett_rr_scheduler #(.NUM_REQ(NR), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [22:0] v);
    req_data[23*i +: 23] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [NR-1:0] exp_grant(input logic [NR-1:0] v, input int p);
    logic [NR-1:0] one;
    one = 1;
    for (int k = 0; k < NR; k++)
      if (v[(p + k) % NR]) return one << ((p + k) % NR);
    return '0;
  endfunction

  typedef struct {
    int          id;
    logic [22:0] op;
    logic [11:0] exp;
  } vec_t;

  typedef struct {
    int id;
    int res;
    int acc;
  } rsp_t;

  vec_t vecs[10];
  rsp_t q[$];

  initial begin
    logic [NR-1:0] one;
    one = 1;

    vecs[0] = '{2, 23'd7000,    12'd342};
    vecs[1] = '{0, 23'd0,       12'd0};
    vecs[2] = '{0, 23'd3328,    12'd3328};
    vecs[3] = '{0, 23'd3329,    12'd0};
    vecs[4] = '{0, 23'd6658,    12'd0};
    vecs[5] = '{0, 23'd8388607, 12'd2856};
    vecs[6] = '{1, 23'd3330,    12'd1};
    vecs[7] = '{3, 23'd6657,    12'd3328};
    vecs[8] = '{0, 23'd9987,    12'd0};
    vecs[9] = '{2, 23'd13315,   12'd3328};

    // Reset state, with requests present during reset.
    rst = 1'b1;
    req_valid = '1;
    req_data = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_busy", busy, 0);
    req_valid = '0;
    rst = 1'b0;
    tick();
    tick();
    check("rst_no_accept_valid", rsp_valid, 0);
    check("rst_no_accept_busy", busy, 0);

    // Vector table, back to back, one response per cycle with 2-cycle latency.
    for (int i = 0; i < 12; i++) begin
      if (i < 10) begin
        req_valid = one << vecs[i].id;
        set_op(vecs[i].id, vecs[i].op);
      end else begin
        req_valid = '0;
      end
      #1;
      if (i < 10) check("vec_ready", req_ready, one << vecs[i].id);
      if (i >= 2) begin
        check("vec_rsp_valid", rsp_valid, 1);
        check("vec_rsp_id", rsp_id, vecs[i-2].id);
        check("vec_rsp_data", rsp_data, vecs[i-2].exp);
      end else begin
        check("vec_latency", rsp_valid, 0);
      end
      tick();
    end
    check("vec_drain_valid", rsp_valid, 0);
    check("vec_drain_busy", busy, 0);

    // All requesters continuously valid.
    do_reset();
    for (int i = 0; i < NR; i++) set_op(i, 23'(100 + i));
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr_all", req_ready, FIXED ? one : (one << (k % NR)));
      tick();
    end
    req_valid = '0;
    tick(); tick(); tick();

    // Backpressure with two entries in flight.
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0010; set_op(1, 23'd5000);
    tick();
    req_valid = 4'b0100; set_op(2, 23'd10000);
    tick();
    req_valid = 4'b1000; set_op(3, 23'd8000);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_ready", req_ready, 0);
      check("bp_valid", rsp_valid, 1);
      check("bp_id", rsp_id, 1);
      check("bp_data", rsp_data, 1671);
      check("bp_busy", busy, 1);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    check("bp_drain1_id", rsp_id, 2);
    check("bp_drain1_data", rsp_data, 13);
    tick();
    check("bp_drain2_id", rsp_id, 3);
    check("bp_drain2_data", rsp_data, 1342);
    tick();
    check("bp_drain_empty", rsp_valid, 0);

    // Reset with both stages occupied.
    do_reset();
    req_valid = 4'b0001; set_op(0, 23'd100);
    tick();
    req_valid = 4'b0010; set_op(1, 23'd200);
    tick();
    req_valid = '0;
    check("mid_pre_valid", rsp_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rsp_valid", rsp_valid, 0);
    check("mid_busy", busy, 0);
    for (int k = 0; k < 3; k++) begin
      check("mid_no_stale", rsp_valid, 0);
      tick();
    end
    req_valid = '1;
    #1;
    check("mid_ptr_zero", req_ready, 4'b0001);

    // Contention between 1 and 3 starting from ptr = 2.
    do_reset();
    req_valid = 4'b0010; set_op(1, 23'd11);
    tick();
    req_valid = 4'b1010; set_op(3, 23'd33);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("fair", req_ready, FIXED ? 4'b0010 : ((k % 2 == 0) ? 4'b1000 : 4'b0010));
      tick();
    end
    req_valid = '0;
    tick(); tick(); tick();

    // Randomized traffic against the reference model.
    do_reset();
    begin
      logic [NR-1:0] pv;
      logic [22:0]   ops[NR];
      logic [NR-1:0] g;
      int            ptr_m;
      int            edge_n;
      int            gi;
      bit            exp_rv;
      bit            done;
      pv = '0;
      ptr_m = 0;
      edge_n = 0;
      done = 1'b0;
      for (int i = 0; i < NR; i++) ops[i] = '0;
      q.delete();
      for (int cyc = 0; cyc < 4400 && !done; cyc++) begin
        if (cyc < 4000) begin
          rsp_ready = ($urandom % 10) < 7;
          for (int i = 0; i < NR; i++) begin
            if (!pv[i] && ($urandom % 3 == 0)) begin
              pv[i] = 1'b1;
              ops[i] = ($urandom % 8 == 0) ? 23'(8388607 - ($urandom % 4000)) : 23'($urandom);
            end
          end
        end else begin
          rsp_ready = 1'b1;
        end
        req_valid = pv;
        for (int i = 0; i < NR; i++) set_op(i, ops[i]);
        #1;
        exp_rv = (q.size() > 0) && (q[0].acc < edge_n);
        g = (exp_rv && !rsp_ready) ? '0 : exp_grant(pv, FIXED ? 0 : ptr_m);
        check("rnd_ready", req_ready, g);
        check("rnd_valid", rsp_valid, exp_rv);
        check("rnd_busy", busy, q.size() > 0);
        if (exp_rv) begin
          check("rnd_id", rsp_id, q[0].id);
          check("rnd_data", rsp_data, q[0].res);
        end
        @(posedge clk);
        if (exp_rv && rsp_ready) void'(q.pop_front());
        if (g != 0) begin
          gi = 0;
          for (int i = 0; i < NR; i++) if (g[i]) gi = i;
          q.push_back('{gi, int'(ops[gi]) % 3329, edge_n + 1});
          pv[gi] = 1'b0;
          ptr_m = (gi + 1) % NR;
        end
        edge_n++;
        #1;
        if (cyc >= 4000 && pv == 0 && q.size() == 0) done = 1'b1;
      end
      check("rnd_drain_done", done, 1);
    end
    req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
